// File: rtl/asg_seq_pkg.sv
// Shared definitions for the arbitrary signal generator segment sequencer.
// Holds the sequencer state encoding, the default microsecond prescale and
// small decode helpers for the segment-count and cycle-count inputs.
package asg_seq_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StArm,
      StStart,
      StPlay,
      StGap,
      StDone
   } seq_state_e;

   // DAC clocks per 1 us at 125 MHz.
   localparam int unsigned US_DIV_DEFAULT = 125;

   // Active segment count: 0 counts as one segment, values above max_seg clamp.
   function automatic int unsigned clamp_nseg(input int unsigned nseg,
                                              input int unsigned max_seg);
      if (nseg == 0) begin
         return 1;
      end else if (nseg > max_seg) begin
         return max_seg;
      end
      return nseg;
   endfunction

   // Cycle count: 0 counts as a single table cycle.
   function automatic int unsigned min1(input int unsigned value);
      return (value == 0) ? 1 : value;
   endfunction

endpackage

// File: rtl/asg_seq_us_tick.sv
// Microsecond prescaler for the inter-repetition gap.
// Counts 0..US_DIV-1 and emits a one-cycle tick on the last count.
// Ports:
//   clk_i  - DAC clock
//   rst_i  - asynchronous active-high reset
//   clr_i  - synchronous clear; holds the count at 0 and suppresses the tick
//   tick_o - one-cycle pulse every US_DIV clocks while not cleared
module asg_seq_us_tick #(
   parameter int unsigned US_DIV = 125
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned CntW = (US_DIV > 1) ? $clog2(US_DIV) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            at_top;

   assign at_top = (cnt_q == CntW'(US_DIV - 1));
   assign tick_o = at_top && !clr_i;

   always_comb begin
      cnt_d = cnt_q + CntW'(1);
      if (clr_i || at_top) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/asg_segment_sequencer.sv
// Segment sequencer for one double-buffered arbitrary signal generator channel.
// Plays up to NSEG table segments, each for a programmed number of table cycles,
// repeats the sequence with an optional microsecond gap, and ping-pongs the
// buffer bank at repetition boundaries.
// Optional feature macro: ASG_SEQ_TRIG_OUT_EN (drives trig_o on segment 0 starts).
// Ports:
//   dac_clk_i, dac_rst_i - DAC clock, asynchronous active-high reset
//   start_i, stop_i      - arm pulse (IDLE/DONE only), abort pulse (highest priority)
//   trig_i               - synchronous trigger level, rising edge used in ARM
//   wrap_i               - datapath pulse: current segment table finished one cycle
//   swap_req_i           - bank swap request pulse
//   nseg_i, seg_ncyc_i   - active segment count, per-segment cycle counts
//   nrep_i, rep_dly_i    - repetitions (0 = infinite), gap between repetitions in us
//   seg_o, seg_start_o   - active segment, one-cycle segment load strobe
//   run_o, bank_o        - datapath advance enable, active buffer bank
//   busy_o, done_o       - sequencing in progress, sequence finished
//   trig_o               - pulse on each segment 0 start (optional feature)
module asg_segment_sequencer
   import asg_seq_pkg::*;
#(
   parameter int unsigned NSEG   = 4,
   parameter int unsigned CYW    = 16,
   parameter int unsigned DLYW   = 32,
   parameter int unsigned US_DIV = US_DIV_DEFAULT
) (
   input  logic                     dac_clk_i,
   input  logic                     dac_rst_i,
   input  logic                     start_i,
   input  logic                     stop_i,
   input  logic                     trig_i,
   input  logic                     wrap_i,
   input  logic                     swap_req_i,
   input  logic [$clog2(NSEG):0]    nseg_i,
   input  logic [NSEG*CYW-1:0]      seg_ncyc_i,
   input  logic [CYW-1:0]           nrep_i,
   input  logic [DLYW-1:0]          rep_dly_i,
   output logic [$clog2(NSEG)-1:0]  seg_o,
   output logic                     seg_start_o,
   output logic                     run_o,
   output logic                     bank_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     trig_o
);

   localparam int unsigned SegW = $clog2(NSEG);

   seq_state_e      state_q, state_d;
   logic [SegW-1:0] seg_q, seg_d;
   logic [CYW-1:0]  cyc_cnt_q, cyc_cnt_d;
   logic [CYW-1:0]  rep_cnt_q, rep_cnt_d;
   logic [DLYW-1:0] dly_cnt_q, dly_cnt_d;
   logic            trig_q, trig_d;
   logic            bank_q, bank_d;
   logic            pend_q, pend_d;

   logic [31:0]     nseg_eff, ncyc_eff, cyc_next, seg_next, rep_next;
   logic [DLYW-1:0] dly_next;
   logic            rep_boundary;
   logic            us_tick;
   logic            tick_clr;
   logic            idle_or_done;

   assign tick_clr = (state_q != StGap) || stop_i;

   asg_seq_us_tick #(
      .US_DIV(US_DIV)
   ) u_us_tick (
      .clk_i (dac_clk_i),
      .rst_i (dac_rst_i),
      .clr_i (tick_clr),
      .tick_o(us_tick)
   );

   assign nseg_eff     = clamp_nseg(32'(nseg_i), NSEG);
   assign ncyc_eff     = min1(32'(seg_ncyc_i[32'(seg_q)*CYW +: CYW]));
   assign cyc_next     = 32'(cyc_cnt_q) + 32'd1;
   assign seg_next     = 32'(seg_q) + 32'd1;
   assign rep_next     = 32'(rep_cnt_q) + 32'd1;
   // Compare against the incremented count so the gap lasts exactly rep_dly_i us.
   assign dly_next     = dly_cnt_q + DLYW'(1);
   assign idle_or_done = (state_q == StIdle) || (state_q == StDone);

   always_comb begin
      state_d      = state_q;
      seg_d        = seg_q;
      cyc_cnt_d    = cyc_cnt_q;
      rep_cnt_d    = rep_cnt_q;
      dly_cnt_d    = dly_cnt_q;
      trig_d       = trig_i;
      bank_d       = bank_q;
      pend_d       = pend_q || swap_req_i;
      rep_boundary = 1'b0;

      unique case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               state_d = StArm;
            end
         end
         StArm: begin
            if (trig_i && !trig_q) begin
               state_d   = StStart;
               seg_d     = '0;
               cyc_cnt_d = '0;
               rep_cnt_d = '0;
            end
         end
         StStart: begin
            state_d = StPlay;
         end
         StPlay: begin
            if (wrap_i) begin
               if (cyc_next < ncyc_eff) begin
                  cyc_cnt_d = CYW'(cyc_next);
               end else if (seg_next < nseg_eff) begin
                  seg_d     = SegW'(seg_next);
                  cyc_cnt_d = '0;
                  state_d   = StStart;
               end else begin
                  rep_cnt_d = CYW'(rep_next);
                  cyc_cnt_d = '0;
                  if ((nrep_i == '0) || (rep_next < 32'(nrep_i))) begin
                     if (rep_dly_i != '0) begin
                        state_d = StGap;
                     end else begin
                        state_d      = StStart;
                        seg_d        = '0;
                        rep_boundary = 1'b1;
                     end
                  end else begin
                     state_d = StDone;
                  end
               end
            end
         end
         StGap: begin
            if (us_tick) begin
               if (dly_next == rep_dly_i) begin
                  state_d      = StStart;
                  seg_d        = '0;
                  dly_cnt_d    = '0;
                  rep_boundary = 1'b1;
               end else begin
                  dly_cnt_d = dly_next;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // A request arriving in the same cycle as the swap is absorbed by it.
      if ((idle_or_done || rep_boundary) && (pend_q || swap_req_i)) begin
         bank_d = ~bank_q;
         pend_d = 1'b0;
      end

      // Abort keeps the bank and any pending swap untouched.
      if (stop_i) begin
         state_d   = StIdle;
         seg_d     = '0;
         cyc_cnt_d = '0;
         rep_cnt_d = '0;
         dly_cnt_d = '0;
         bank_d    = bank_q;
         pend_d    = pend_q || swap_req_i;
      end
   end

   always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
      if (dac_rst_i) begin
         state_q   <= StIdle;
         seg_q     <= '0;
         cyc_cnt_q <= '0;
         rep_cnt_q <= '0;
         dly_cnt_q <= '0;
         trig_q    <= 1'b0;
         bank_q    <= 1'b0;
         pend_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         seg_q     <= seg_d;
         cyc_cnt_q <= cyc_cnt_d;
         rep_cnt_q <= rep_cnt_d;
         dly_cnt_q <= dly_cnt_d;
         trig_q    <= trig_d;
         bank_q    <= bank_d;
         pend_q    <= pend_d;
      end
   end

   assign seg_o       = seg_q;
   assign seg_start_o = (state_q == StStart);
   assign run_o       = (state_q == StStart) || (state_q == StPlay);
   assign bank_o      = bank_q;
   assign busy_o      = !idle_or_done;
   assign done_o      = (state_q == StDone);

`ifdef ASG_SEQ_TRIG_OUT_EN
   assign trig_o = seg_start_o && (seg_q == '0);
`else
   assign trig_o = 1'b0;
`endif

endmodule

// File: tb/tb_asg_segment_sequencer.sv
module tb_asg_segment_sequencer;

   localparam int NSEG   = 4;
   localparam int CYW    = 16;
   localparam int DLYW   = 32;
   localparam int US_DIV = 125;
   localparam int BUDGET = 5000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, stop = 1'b0, trig = 1'b0, wrap = 1'b0, swap = 1'b0;
   logic [2:0]  nseg = '0;
   logic [63:0] ncyc = '0;
   logic [15:0] nrep = '0;
   logic [31:0] dly = '0;
   logic [1:0]  seg;
   logic        seg_start, run, bank, busy, done, trig_o;

   int   nchk = 0;
   int   nerr = 0;
   int   cyc_idx = 0;
   logic exp_bank = 1'b0;

   typedef struct {
      int seg;
      int lat;
   } exp_ev_t;

   typedef struct {
      logic [2:0]  nseg;
      logic [63:0] ncyc;
      logic [15:0] nrep;
      logic [31:0] dly;
      bit          spur;
      int          exp_starts;
      int          exp_wraps;
   } vec_t;

   exp_ev_t exp_q[$];
   int      model_wraps;
   int      model_neff;
   vec_t    vecs[5];

   always #5 clk = ~clk;

   asg_segment_sequencer #(
      .NSEG  (NSEG),
      .CYW   (CYW),
      .DLYW  (DLYW),
      .US_DIV(US_DIV)
   ) dut (
      .dac_clk_i  (clk),
      .dac_rst_i  (rst),
      .start_i    (start),
      .stop_i     (stop),
      .trig_i     (trig),
      .wrap_i     (wrap),
      .swap_req_i (swap),
      .nseg_i     (nseg),
      .seg_ncyc_i (ncyc),
      .nrep_i     (nrep),
      .rep_dly_i  (dly),
      .seg_o      (seg),
      .seg_start_o(seg_start),
      .run_o      (run),
      .bank_o     (bank),
      .busy_o     (busy),
      .done_o     (done),
      .trig_o     (trig_o)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      cyc_idx++;
   endtask

   // Expected segment starts and wrap total, derived from the sequencing rules.
   task automatic model_build(input vec_t v);
      int neff, n, lat;
      neff = (v.nseg == 0) ? 1 : ((int'(v.nseg) > NSEG) ? NSEG : int'(v.nseg));
      model_neff  = neff;
      model_wraps = 0;
      exp_q.delete();
      for (int r = 0; r < int'(v.nrep); r++) begin
         for (int s = 0; s < neff; s++) begin
            if (r == 0 && s == 0) lat = 0;
            else if (s == 0 && v.dly > 0) lat = int'(v.dly) * US_DIV + 1;
            else lat = 1;
            exp_q.push_back('{seg: s, lat: lat});
            n = int'(v.ncyc[s*CYW +: CYW]);
            model_wraps += (n == 0) ? 1 : n;
         end
      end
   endtask

   task automatic run_seq(input string name, input vec_t v);
      int      starts = 0, wraps = 0, last_wrap = 0, budget = 0;
      int      want_starts, want_wraps;
      exp_ev_t ev;
      logic    exp_trig;
      nseg = v.nseg; ncyc = v.ncyc; nrep = v.nrep; dly = v.dly;
      model_build(v);
      want_starts = (v.exp_starts < 0) ? exp_q.size() : v.exp_starts;
      want_wraps  = (v.exp_starts < 0) ? model_wraps : v.exp_wraps;
      start = 1'b1; cyc(); start = 1'b0;
      check({name, " armed"}, {busy, run}, 2'b10);
      if (v.spur) begin
         for (int i = 0; i < 3; i++) begin
            wrap = 1'b1; cyc();
         end
         wrap = 1'b0;
      end
      trig = 1'b1; cyc(); trig = 1'b0;
      check({name, " trig latency"}, seg_start, 1'b1);
      while (!done && budget < BUDGET) begin
         if (seg_start) begin
            starts++;
            if (exp_q.size() > 0) begin
               ev = exp_q.pop_front();
               check({name, " seg"}, seg, ev.seg);
               if (ev.lat != 0) check({name, " start latency"}, cyc_idx - last_wrap, ev.lat);
`ifdef ASG_SEQ_TRIG_OUT_EN
               exp_trig = (ev.seg == 0);
`else
               exp_trig = 1'b0;
`endif
               check({name, " trig_o"}, trig_o, exp_trig);
               check({name, " bank"}, bank, exp_bank);
            end else begin
               check({name, " unexpected start"}, starts, want_starts);
            end
         end
         if (run && !seg_start && $urandom_range(0, 1) == 1) begin
            wrap = 1'b1; wraps++; last_wrap = cyc_idx;
         end else if (v.spur && busy && !run && $urandom_range(0, 3) == 0) begin
            wrap = 1'b1;
         end
         cyc(); wrap = 1'b0; budget++;
      end
      check({name, " no timeout"}, budget < BUDGET, 1'b1);
      check({name, " starts"}, starts, want_starts);
      check({name, " wraps"}, wraps, want_wraps);
      check({name, " done state"}, {done, run, busy}, 3'b100);
      check({name, " seg holds"}, seg, model_neff - 1);
      check({name, " model drained"}, exp_q.size(), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int   starts, budget;
      bit   seen;
      vec_t rv;

      // Reset state
      #2;
      check("reset outputs", {seg, seg_start, run, bank, busy, done, trig_o}, 0);
      cyc(); cyc(); rst = 1'b0;
      cyc();
      check("idle after reset", {busy, done, run}, 0);

      vecs[0] = '{3'd4, {16'd4, 16'd3, 16'd2, 16'd1}, 16'd1, 32'd0, 1'b0, 4, 10};
      vecs[1] = '{3'd1, {16'd0, 16'd0, 16'd0, 16'd1}, 16'd3, 32'd2, 1'b0, 3, 3};
      vecs[2] = '{3'd0, 64'd0, 16'd1, 32'd0, 1'b0, 1, 1};
      vecs[3] = '{3'd7, {16'd1, 16'd1, 16'd0, 16'd2}, 16'd2, 32'd0, 1'b0, 8, 10};
      vecs[4] = '{3'd2, {16'd0, 16'd0, 16'd1, 16'd3}, 16'd2, 32'd1, 1'b1, 4, 8};
      for (int i = 0; i < 5; i++) run_seq($sformatf("vec%0d", i), vecs[i]);

      for (int i = 0; i < 6; i++) begin
         rv.nseg = 3'($urandom_range(0, 7));
         for (int s = 0; s < NSEG; s++) rv.ncyc[s*CYW +: CYW] = 16'($urandom_range(0, 3));
         rv.nrep = 16'($urandom_range(1, 3));
         rv.dly  = 32'($urandom_range(0, 1));
         rv.spur = 1'($urandom_range(0, 1));
         rv.exp_starts = -1;
         rv.exp_wraps  = -1;
         run_seq($sformatf("rand%0d", i), rv);
      end

      // Infinite repetitions, then abort mid-PLAY with a coincident start
      nseg = 3'd2; ncyc = {16'd0, 16'd0, 16'd1, 16'd1}; nrep = 16'd0; dly = 32'd0;
      start = 1'b1; cyc(); start = 1'b0;
      trig = 1'b1; cyc(); trig = 1'b0;
      starts = 0; budget = 0;
      while (starts < 8 && budget < 200) begin
         if (seg_start) begin
            check("loop seg", seg, starts % 2);
            starts++;
         end
         if (run && !seg_start) wrap = 1'b1;
         cyc(); wrap = 1'b0; budget++;
      end
      check("loop starts", starts, 8);
      budget = 0;
      while (!(run && !seg_start) && budget < 10) begin
         cyc(); budget++;
      end
      check("loop still busy", {busy, run}, 2'b11);
      stop = 1'b1; start = 1'b1; cyc(); stop = 1'b0; start = 1'b0;
      check("stop run/busy", {run, busy}, 2'b00);
      cyc(); cyc();
      check("stop ignores start", {busy, seg}, 0);

      // Bank swap deferred to the next repetition boundary
      nrep = 16'd2;
      start = 1'b1; cyc(); start = 1'b0;
      trig = 1'b1; cyc(); trig = 1'b0;
      cyc();
      wrap = 1'b1; cyc(); wrap = 1'b0;
      check("swap seq seg1", {seg_start, seg}, {1'b1, 2'd1});
      cyc();
      swap = 1'b1; cyc(); swap = 1'b0;
      check("swap deferred", bank, exp_bank);
      cyc(); cyc();
      check("swap still deferred", bank, exp_bank);
      wrap = 1'b1; cyc(); wrap = 1'b0;
      exp_bank = ~exp_bank;
      check("swap at boundary", {seg_start, seg, bank}, {1'b1, 2'd0, exp_bank});
      cyc(); wrap = 1'b1; cyc(); wrap = 1'b0;
      cyc(); wrap = 1'b1; cyc(); wrap = 1'b0;
      check("swap single toggle", {done, bank}, {1'b1, exp_bank});
      stop = 1'b1; cyc(); stop = 1'b0;
      swap = 1'b1; cyc(); swap = 1'b0;
      exp_bank = ~exp_bank;
      check("swap in idle", bank, exp_bank);
      cyc();
      check("swap idle single", bank, exp_bank);

      // Trigger held high must not retrigger
      nseg = 3'd1; ncyc = 64'd1; nrep = 16'd1; dly = 32'd0;
      trig = 1'b1; cyc();
      start = 1'b1; cyc(); start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         seen |= seg_start;
      end
      check("held trig no start", seen, 1'b0);
      check("held trig armed", {busy, run}, 2'b10);
      trig = 1'b0; cyc(); trig = 1'b1; cyc();
      check("retrig start", seg_start, 1'b1);
      trig = 1'b0; cyc();
      wrap = 1'b1; cyc(); wrap = 1'b0;
      check("retrig done", {done, run}, 2'b10);
      swap = 1'b1; cyc(); swap = 1'b0;
      exp_bank = ~exp_bank;
      check("swap in done", bank, exp_bank);

      // Asynchronous reset in the middle of a gap
      nrep = 16'd2; dly = 32'd2;
      start = 1'b1; cyc(); start = 1'b0;
      trig = 1'b1; cyc(); trig = 1'b0;
      cyc();
      wrap = 1'b1; cyc(); wrap = 1'b0;
      for (int i = 0; i < 10; i++) cyc();
      check("in gap", {busy, run, seg_start}, 3'b100);
      #3 rst = 1'b1;
      #1 check("async reset outputs", {seg, seg_start, run, bank, busy, done, trig_o}, 0);
      cyc(); cyc();
      rst = 1'b0;
      exp_bank = 1'b0;
      for (int i = 0; i < 5; i++) cyc();
      check("idle after gap reset", {busy, done, run, bank}, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/asg_segment_sequencer.md
Name: asg_segment_sequencer

Overview:
- Control block for the double-buffered arbitrary signal generator channel. It sequences up to NSEG table segments, each played a programmed number of table cycles.
- It repeats the whole sequence with a programmable 1 us-granular gap and ping-pongs the double-buffer bank at repetition boundaries.
- It drives the per-channel table-read datapath: segment select, start/load strobe, run gate. It consumes the datapath's table-wrap pulse.

Parameters:
- NSEG, 4, number of segments
- CYW, 16, cycle-count and repetition-count width
- DLYW, 32, inter-repetition delay width (us units)
- US_DIV, 125, dac clocks per 1 us tick (125 MHz)

Ports:
- dac_clk_i  in  1  DAC clock
- dac_rst_i  in  1  asynchronous active-high reset
- start_i  in  1  pulse; arm sequencer (honoured in IDLE/DONE only)
- stop_i  in  1  pulse; abort to IDLE, highest priority
- trig_i  in  1  level trigger, already synchronous; rising edge detected internally
- wrap_i  in  1  pulse from datapath: current segment table completed one cycle
- swap_req_i  in  1  pulse; request bank swap
- nseg_i  in  $clog2(NSEG)+1  active segments; 0 treated as 1, >NSEG clamped to NSEG
- seg_ncyc_i  in  NSEG*CYW  cycles per segment, segment k at [k*CYW+:CYW]; 0 treated as 1
- nrep_i  in  CYW  sequence repetitions; 0 = infinite
- rep_dly_i  in  DLYW  gap between repetitions in us
- seg_o  out  $clog2(NSEG)  active segment index
- seg_start_o  out  1  one-cycle strobe: datapath loads segment reset offset
- run_o  out  1  datapath pointer advance enable
- bank_o  out  1  active buffer bank
- busy_o  out  1  state not IDLE/DONE
- done_o  out  1  high in DONE
- trig_o  out  1  one-cycle pulse on each seg_start_o of segment 0 (optional feature)

Behaviour:
- Reset: state IDLE; all outputs 0; counters, edge register and swap-pending flag cleared.
- Configuration inputs are sampled live. Software changes them only in IDLE/DONE.
- States: IDLE, ARM, START, PLAY, GAP, DONE.
- IDLE/DONE + start_i -> ARM next cycle. done_o drops when leaving DONE.
- ARM: trig_i rising edge (trig_i & ~trig_q) -> START with seg=0, cyc_cnt=0, rep_cnt=0.
- START (exactly 1 cycle):
  - seg_start_o=1, run_o=1 -> PLAY.
  - wrap_i is ignored in START, GAP, ARM, IDLE and DONE.
- PLAY: run_o=1. On wrap_i:
  - If cyc_cnt+1 < ncyc[seg]: cyc_cnt++.
  - Else if seg < nseg-1: seg++, cyc_cnt=0, -> START.
  - Else (repetition end): rep_cnt++.
    - If nrep_i==0 or rep_cnt+1 < nrep_i: -> GAP if rep_dly_i>0, else START with seg=0.
    - Otherwise -> DONE.
- GAP: run_o=0, seg_o holds last segment.
  - us prescaler counts 0..US_DIV-1; dly_cnt increments on wrap of the prescaler.
  - When dly_cnt==rep_dly_i -> START with seg=0, prescaler and dly_cnt cleared.
- DONE: run_o=0, done_o=1, seg_o holds.
- stop_i in any state: -> IDLE next cycle, run_o=0, counters cleared. A coincident start_i is ignored.
- Bank swap:
  - swap_req_i sets pending.
  - In IDLE/DONE, the swap applies on the next cycle.
  - Otherwise it applies on the cycle entering START of segment 0 at a repetition boundary (not the first START after ARM).
  - Applying toggles bank_o and clears pending. A request coincident with application is consumed by it (single toggle).
  - stop_i does not clear pending.
- Latency:
  - trig edge to seg_start_o: 1 cycle.
  - Last wrap_i to next seg_start_o: 1 cycle (no gap) or rep_dly_i*US_DIV+1 cycles.
- Counter arithmetic is unsigned with no saturation. rep_cnt with nrep_i==0 wraps harmlessly.

Optional Feature:
- Macro ASG_SEQ_TRIG_OUT_EN.
- Defined: trig_o pulses with seg_start_o whenever seg_o==0, for external scope/slave sync.
- Undefined: trig_o tied 0, and the associated logic is absent.

Decomposition:
- Package asg_seq_pkg holds:
  - the state enum (IDLE, ARM, START, PLAY, GAP, DONE)
  - the US_DIV default constant
  - a helper function for the clamped nseg / min-1 ncyc decode
- One sub-module: asg_seq_us_tick, a prescaler with clear input. It produces a 1-cycle tick every US_DIV clocks.

Test Plan:
- Setup nseg=4, ncyc={1,2,3,4}, nrep=1, trig edge. Expect seg_start_o on segments 0,1,2,3 after 1,2,3,4 wrap_i respectively. After the 10th wrap: DONE, done_o=1, run_o=0.
- nseg=1, ncyc=1, nrep=3, rep_dly=2. Expect 3 seg_start_o on segment 0, gaps of exactly 251 cycles between last wrap_i and next seg_start_o, then DONE.
- nrep=0, rep_dly=0: sequence loops indefinitely with 1-cycle START bubbles. stop_i mid-PLAY gives run_o=0 and busy_o=0 next cycle.
- swap_req_i mid-PLAY of segment 1 (nseg=2): bank_o unchanged until START of segment 0 of the next repetition, then toggles once. swap_req_i in IDLE toggles after 1 cycle.
- nseg_i=0 and ncyc=0: behaves as one segment, one cycle. wrap_i during ARM/GAP is ignored (counts unaffected). trig_i held high does not retrigger.
- Reset asserted mid-GAP: all outputs 0 asynchronously. After release the block stays IDLE until start_i.
